// File: rtl/ppi_arb_pkg.sv
// Shared types and constants for the PPI access arbiter.
package ppi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_HOST
    } owner_t;

    // 8255 register map
    localparam logic [1:0] PPI_PA   = 2'd0;
    localparam logic [1:0] PPI_PB   = 2'd1;
    localparam logic [1:0] PPI_PC   = 2'd2;
    localparam logic [1:0] PPI_CTRL = 2'd3;

endpackage

// File: rtl/ppi_access_arbiter_if.sv
// Requester and PPI-side bus bundle for ppi_access_arbiter.
// Handshake: a requester raises req (level) with we/addr/wdata stable and
// holds it until ack pulses for one cycle; rdata is valid while ack is high
// and holds afterwards. There is no queueing: a req dropped before grant is lost.
// slave  = arbiter view; master = surrounding system (decoder, host port, PPI).
interface ppi_access_arbiter_if;
    logic       cpu_req;
    logic       cpu_we;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       cpu_wait;

    logic       host_req;
    logic       host_we;
    logic [1:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;

    logic [1:0] ppi_addr;
    logic [7:0] ppi_din;
    logic       ppi_csn;
    logic       ppi_rdn;
    logic       ppi_wrn;
    logic [7:0] ppi_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_wait,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output ppi_addr, ppi_din, ppi_csn, ppi_rdn, ppi_wrn,
        input  ppi_dout
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_wait,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  ppi_addr, ppi_din, ppi_csn, ppi_rdn, ppi_wrn,
        output ppi_dout
    );
endinterface

// File: rtl/ppi_arb_grant.sv
// Grant decision between the CPU and host requesters.
// Macro PPI_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests go to the
// requester not served last; when undefined, the CPU always wins.
module ppi_arb_grant
    import ppi_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   host_req,
    input  owner_t last_owner,
    output logic   gnt_valid,
    output owner_t gnt_owner
);

    // Pick a winner from the pending requests.
    always_comb begin
        gnt_valid = cpu_req | host_req;
        gnt_owner = OWN_CPU;
`ifdef PPI_ARB_ROUND_ROBIN_EN
        if (cpu_req && host_req) begin
            gnt_owner = (last_owner == OWN_CPU) ? OWN_HOST : OWN_CPU;
        end else if (host_req) begin
            gnt_owner = OWN_HOST;
        end
`else
        if (!cpu_req && host_req) begin
            gnt_owner = OWN_HOST;
        end
`endif
    end

`ifndef PPI_ARB_ROUND_ROBIN_EN
    // Fixed priority ignores history.
    logic unused_last_owner;
    assign unused_last_owner = (last_owner == OWN_HOST);
`endif

endmodule

// File: rtl/ppi_access_arbiter.sv
// Shares the 8255 PPI CPU-side bus between the Z80 I/O decoder and the host
// port, turning each grant into a setup/strobe/hold/recovery strobe sequence.
// Macro PPI_ARB_ROUND_ROBIN_EN selects round-robin instead of CPU priority.
module ppi_access_arbiter
    import ppi_arb_pkg::*;
#(
    parameter int STROBE_CYC   = 2,
    parameter int RECOVERY_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    ppi_access_arbiter_if.slave bus,
    output state_t              dbg_state,
    output owner_t              dbg_owner
);

    localparam logic [3:0] STROBE_LOAD  = 4'(STROBE_CYC - 1);
    localparam logic [3:0] RECOVER_LOAD = 4'(RECOVERY_CYC - 1);

    generate
        if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
            $error("STROBE_CYC must be within 1..15");
        end
        if (RECOVERY_CYC < 1 || RECOVERY_CYC > 15) begin : g_bad_recovery
            $error("RECOVERY_CYC must be within 1..15");
        end
    endgenerate

    state_t     state;
    state_t     state_nxt;
    owner_t     owner;      // also serves as the round-robin "last served" pointer
    logic       lat_we;
    logic [3:0] cnt;
    logic [1:0] addr_q;
    logic [7:0] din_q;
    logic [7:0] cpu_rdata_q;
    logic [7:0] host_rdata_q;
    logic       gnt_valid;
    owner_t     gnt_owner;

    logic       active;
    logic       cpu_ack_c;
    logic       host_ack_c;

    ppi_arb_grant u_grant (
        .cpu_req    (bus.cpu_req),
        .host_req   (bus.host_req),
        .last_owner (owner),
        .gnt_valid  (gnt_valid),
        .gnt_owner  (gnt_owner)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; STROBE and RECOVER run until the down-counter hits zero.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  if (cnt == 4'd0) state_nxt = HOLD;
            HOLD:    state_nxt = RECOVER;
            RECOVER: if (cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant latches, phase counter and per-owner read data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner        <= OWN_CPU;
            lat_we       <= 1'b0;
            cnt          <= 4'd0;
            addr_q       <= 2'd0;
            din_q        <= 8'd0;
            cpu_rdata_q  <= 8'hFF;
            host_rdata_q <= 8'hFF;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        owner <= gnt_owner;
                        if (gnt_owner == OWN_HOST) begin
                            lat_we <= bus.host_we;
                            addr_q <= bus.host_addr;
                            din_q  <= bus.host_wdata;
                        end else begin
                            lat_we <= bus.cpu_we;
                            addr_q <= bus.cpu_addr;
                            din_q  <= bus.cpu_wdata;
                        end
                    end
                end
                SETUP:   cnt <= STROBE_LOAD;
                STROBE:  if (cnt != 4'd0) cnt <= cnt - 4'd1;
                HOLD: begin
                    cnt <= RECOVER_LOAD;
                    if (!lat_we) begin
                        if (owner == OWN_CPU) cpu_rdata_q  <= bus.ppi_dout;
                        else                  host_rdata_q <= bus.ppi_dout;
                    end
                end
                RECOVER: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                default: cnt <= 4'd0;
            endcase
        end
    end

    // Strobes, acks, read data bypass during HOLD and the Z80 wait line.
    always_comb begin
        active         = (state == SETUP) || (state == STROBE) || (state == HOLD);
        cpu_ack_c      = (state == HOLD) && (owner == OWN_CPU);
        host_ack_c     = (state == HOLD) && (owner == OWN_HOST);
        bus.ppi_csn    = ~active;
        bus.ppi_rdn    = ~((state == STROBE) && !lat_we);
        bus.ppi_wrn    = ~((state == STROBE) && lat_we);
        bus.cpu_ack    = cpu_ack_c;
        bus.host_ack   = host_ack_c;
        bus.cpu_rdata  = (cpu_ack_c && !lat_we)  ? bus.ppi_dout : cpu_rdata_q;
        bus.host_rdata = (host_ack_c && !lat_we) ? bus.ppi_dout : host_rdata_q;
        bus.cpu_wait   = bus.cpu_req & ~(active && (owner == OWN_CPU));
    end

    assign bus.ppi_addr = addr_q;
    assign bus.ppi_din  = din_q;
    assign dbg_state    = state;
    assign dbg_owner    = owner;

endmodule

// File: tb/tb_ppi_access_arbiter.sv
// Testbench for ppi_access_arbiter with a simple 8255 register model.
`timescale 1ns/1ps
module tb_ppi_access_arbiter;
    import ppi_arb_pkg::*;

    localparam int STROBE_CYC   = 2;
    localparam int RECOVERY_CYC = 1;
    localparam int LAT          = STROBE_CYC + 2;
`ifdef PPI_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;
    owner_t dbg_owner;

    ppi_access_arbiter_if bus();

    ppi_access_arbiter #(.STROBE_CYC(STROBE_CYC), .RECOVERY_CYC(RECOVERY_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_owner (dbg_owner)
    );

    always #5 clk = ~clk;

    // ---------------- PPI device model ----------------
    logic [7:0] ppi_regs [4];
    logic [7:0] ppi_dout_q;
    logic       rdn_prev;
    int         rd_edges;

    always @(posedge clk) begin
        if (rst) begin
            ppi_regs[0] <= 8'h11;
            ppi_regs[1] <= 8'h5A;
            ppi_regs[2] <= 8'h33;
            ppi_regs[3] <= 8'h00;
            ppi_dout_q  <= 8'h00;
            rdn_prev    <= 1'b1;
            rd_edges    <= 0;
        end else begin
            if (!bus.ppi_csn && !bus.ppi_wrn) ppi_regs[bus.ppi_addr] <= bus.ppi_din;
            if (!bus.ppi_csn && !bus.ppi_rdn) ppi_dout_q <= ppi_regs[bus.ppi_addr];
            if (!bus.ppi_rdn && rdn_prev) rd_edges <= rd_edges + 1;
            rdn_prev <= bus.ppi_rdn;
        end
    end
    assign bus.ppi_dout = ppi_dout_q;

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [4];
    logic [7:0] exp_cpu_rd;
    logic [7:0] exp_host_rd;
    owner_t     model_last;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic reset_model();
        ref_mem[0] = 8'h11;
        ref_mem[1] = 8'h5A;
        ref_mem[2] = 8'h33;
        ref_mem[3] = 8'h00;
        exp_cpu_rd  = 8'hFF;
        exp_host_rd = 8'hFF;
        model_last  = OWN_CPU;
    endtask

    // One isolated access; caller is at a negedge with the DUT idle.
    task automatic do_access(input owner_t who, input logic we, input logic [1:0] addr,
                             input logic [7:0] wdata, input string tag, output logic [7:0] got_rd);
        int lat, csn_lo, rd_lo, wr_lo, busbad, waitbad;
        logic [7:0] exp_own, exp_oth, oth_rd;
        lat = 0; csn_lo = 0; rd_lo = 0; wr_lo = 0; busbad = 0; waitbad = 0;
        got_rd = 8'h00;
        if (who == OWN_CPU) begin
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
            #1;
            check({tag, "_wait_pending"}, 32'(bus.cpu_wait), 32'd1);
        end else begin
            bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wdata; bus.host_req = 1'b1;
        end
        for (int k = 1; k <= 64 && lat == 0; k++) begin
            @(negedge clk);
            if (!bus.ppi_csn) begin
                csn_lo++;
                if (bus.ppi_addr !== addr || (we && bus.ppi_din !== wdata)) busbad++;
            end
            if (!bus.ppi_rdn) rd_lo++;
            if (!bus.ppi_wrn) wr_lo++;
            if (who == OWN_CPU && bus.cpu_wait) waitbad++;
            if ((who == OWN_CPU) ? bus.cpu_ack : bus.host_ack) begin
                lat    = k;
                got_rd = (who == OWN_CPU) ? bus.cpu_rdata : bus.host_rdata;
            end
        end
        bus.cpu_req = 1'b0;
        bus.host_req = 1'b0;
        if (!we) begin
            if (who == OWN_CPU) exp_cpu_rd = ref_mem[addr];
            else                exp_host_rd = ref_mem[addr];
        end else begin
            ref_mem[addr] = wdata;
        end
        model_last = who;
        exp_own = (who == OWN_CPU) ? exp_cpu_rd : exp_host_rd;
        exp_oth = (who == OWN_CPU) ? exp_host_rd : exp_cpu_rd;
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_csn_cycles"}, 32'(csn_lo), 32'(LAT));
        check({tag, "_rdn_cycles"}, 32'(rd_lo), we ? 32'd0 : 32'(STROBE_CYC));
        check({tag, "_wrn_cycles"}, 32'(wr_lo), we ? 32'(STROBE_CYC) : 32'd0);
        check({tag, "_bus_stable"}, 32'(busbad), 32'd0);
        check({tag, "_wait_owner"}, 32'(waitbad), 32'd0);
        check({tag, "_rdata_at_ack"}, 32'(got_rd), 32'(exp_own));
        @(negedge clk);
        oth_rd = (who == OWN_CPU) ? bus.host_rdata : bus.cpu_rdata;
        check({tag, "_rdata_held"}, 32'((who == OWN_CPU) ? bus.cpu_rdata : bus.host_rdata), 32'(exp_own));
        check({tag, "_other_rdata"}, 32'(oth_rd), 32'(exp_oth));
        if (we) check({tag, "_ppi_written"}, 32'(ppi_regs[addr]), 32'(wdata));
        repeat (RECOVERY_CYC) @(negedge clk);
    endtask

    typedef struct {
        owner_t     who;
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] rd;
        int acks, gap, e0, hacks, cacks, csn_after, waitbad, cn, hn;
        logic [7:0] b2b_rd [2];
        logic [7:0] exp_order, obs_order;
        int         obs_n;
        owner_t     last, g;

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
        rst = 1'b1;
        reset_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_csn", 32'(bus.ppi_csn), 32'd1);
        check("rst_rdn", 32'(bus.ppi_rdn), 32'd1);
        check("rst_wrn", 32'(bus.ppi_wrn), 32'd1);
        check("rst_addr", 32'(bus.ppi_addr), 32'd0);
        check("rst_din", 32'(bus.ppi_din), 32'd0);
        check("rst_acks", 32'({bus.cpu_ack, bus.host_ack}), 32'd0);
        check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'hFF);
        check("rst_host_rdata", 32'(bus.host_rdata), 32'hFF);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_owner", 32'(dbg_owner), 32'(OWN_CPU));

        // Directed single accesses
        vecs[0] = '{OWN_CPU,  1'b1, PPI_CTRL, 8'h82, 8'hFF};
        vecs[1] = '{OWN_CPU,  1'b0, PPI_PB,   8'h00, 8'h5A};
        vecs[2] = '{OWN_HOST, 1'b0, PPI_CTRL, 8'h00, 8'h82};
        vecs[3] = '{OWN_HOST, 1'b1, PPI_PA,   8'hC3, 8'h82};
        vecs[4] = '{OWN_CPU,  1'b0, PPI_PA,   8'h00, 8'hC3};
        vecs[5] = '{OWN_HOST, 1'b0, PPI_PC,   8'h00, 8'h33};
        for (int i = 0; i < 6; i++) begin
            do_access(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i), rd);
            check($sformatf("vec%0d_table_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
        end

        // Back-to-back CPU reads of port B with req held across the ack
        e0 = rd_edges; acks = 0; gap = 0;
        bus.cpu_we = 1'b0; bus.cpu_addr = PPI_PB; bus.cpu_req = 1'b1;
        for (int k = 0; k < 100 && acks < 2; k++) begin
            @(negedge clk);
            if (acks == 1 && bus.ppi_csn) gap++;
            if (bus.cpu_ack) begin
                b2b_rd[acks] = bus.cpu_rdata;
                acks++;
                if (acks == 2) bus.cpu_req = 1'b0;
            end
        end
        repeat (RECOVERY_CYC + 1) @(negedge clk);
        exp_cpu_rd = ref_mem[PPI_PB];
        model_last = OWN_CPU;
        check("b2b_acks", 32'(acks), 32'd2);
        check("b2b_csn_gap", 32'(gap), 32'(RECOVERY_CYC + 1));
        check("b2b_rdata0", 32'(b2b_rd[0]), 32'(ref_mem[PPI_PB]));
        check("b2b_rdata1", 32'(b2b_rd[1]), 32'(ref_mem[PPI_PB]));
        check("b2b_read_edges", 32'(rd_edges - e0), 32'd2);

        // Host req pulsed for one cycle during a CPU strobe is lost
        hacks = 0; cacks = 0; csn_after = 0;
        bus.cpu_we = 1'b1; bus.cpu_addr = PPI_PC; bus.cpu_wdata = 8'h44; bus.cpu_req = 1'b1;
        bus.host_we = 1'b1; bus.host_addr = PPI_PA; bus.host_wdata = 8'hEE;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 2) bus.host_req = 1'b1;
            if (k == 3) bus.host_req = 1'b0;
            if (bus.host_ack) hacks++;
            if (bus.cpu_ack) begin
                cacks++;
                bus.cpu_req = 1'b0;
            end else if (cacks > 0 && !bus.ppi_csn) begin
                csn_after++;
            end
        end
        ref_mem[PPI_PC] = 8'h44;
        model_last = OWN_CPU;
        check("pulse_cpu_acks", 32'(cacks), 32'd1);
        check("pulse_host_acks", 32'(hacks), 32'd0);
        check("pulse_no_extra_access", 32'(csn_after), 32'd0);
        check("pulse_pa_untouched", 32'(ppi_regs[PPI_PA]), 32'(ref_mem[PPI_PA]));
        check("pulse_pc_written", 32'(ppi_regs[PPI_PC]), 32'h44);

        // Both requesters pending for four accesses each
        exp_order = 8'h00; last = model_last; cn = 4; hn = 4;
        for (int i = 0; i < 8; i++) begin
            if (cn > 0 && hn > 0) g = (RR && last == OWN_CPU) ? OWN_HOST : OWN_CPU;
            else                  g = (cn > 0) ? OWN_CPU : OWN_HOST;
            exp_order[i] = (g == OWN_HOST);
            if (g == OWN_CPU) cn--; else hn--;
            last = g;
        end
        obs_order = 8'h00; obs_n = 0; cn = 0; hn = 0; waitbad = 0;
        bus.cpu_we = 1'b0;  bus.cpu_addr = PPI_PC;
        bus.host_we = 1'b0; bus.host_addr = PPI_PC;
        bus.cpu_req = 1'b1; bus.host_req = 1'b1;
        for (int k = 0; k < 300 && (cn < 4 || hn < 4); k++) begin
            @(negedge clk);
            if (bus.cpu_ack && bus.cpu_wait) waitbad++;
            if (bus.host_ack && bus.cpu_req && !bus.cpu_wait) waitbad++;
            if (bus.cpu_ack && obs_n < 8) begin
                obs_order[obs_n] = 1'b0; obs_n++; cn++;
                if (cn == 4) bus.cpu_req = 1'b0;
            end
            if (bus.host_ack && obs_n < 8) begin
                obs_order[obs_n] = 1'b1; obs_n++; hn++;
                if (hn == 4) bus.host_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0; bus.host_req = 1'b0;
        repeat (RECOVERY_CYC + 1) @(negedge clk);
        model_last = last;
        exp_cpu_rd = ref_mem[PPI_PC];
        exp_host_rd = ref_mem[PPI_PC];
        check("dual_count", 32'(obs_n), 32'd8);
        check("dual_order", 32'(obs_order), 32'(exp_order));
        check("dual_wait", 32'(waitbad), 32'd0);
        check("dual_cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu_rd));
        check("dual_host_rdata", 32'(bus.host_rdata), 32'(exp_host_rd));

        // Randomised single accesses against the reference memory
        for (int i = 0; i < 30; i++) begin
            do_access(owner_t'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                      $sformatf("rnd%0d", i), rd);
        end

        // Reset during the strobe of a CPU write
        bus.cpu_we = 1'b1; bus.cpu_addr = PPI_CTRL; bus.cpu_wdata = 8'h99; bus.cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        check("rstmid_in_strobe", 32'(bus.ppi_wrn), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_wrn", 32'(bus.ppi_wrn), 32'd1);
        check("rstmid_csn", 32'(bus.ppi_csn), 32'd1);
        check("rstmid_ack", 32'(bus.cpu_ack), 32'd0);
        check("rstmid_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        reset_model();
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.cpu_ack || !bus.ppi_csn) acks++;
        end
        check("rstmid_no_replay", 32'(acks), 32'd0);
        do_access(OWN_CPU, 1'b0, PPI_CTRL, 8'h00, "post_rst_read", rd);
        do_access(OWN_HOST, 1'b1, PPI_PB, 8'hA5, "post_rst_write", rd);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
